uart_tx_formatter: RTL and testbench
====================================

Name: uart_tx_formatter

Overview:
- Transmit-side counterpart of the UART command interpreter: formats a register read response and streams it byte-by-byte into the UART transmitter.
- On i_start it captures an 8-bit address and 32-bit data word and emits the frame: response key, raw address byte, 8 lowercase ASCII hex characters, then optionally CR LF.
- Hex characters go out least-significant nibble first, the same order the interpreter expects for an edit payload. A captured response body can therefore be replayed as an edit command.

Parameters:
- RESPKEY, 114, first byte of every frame ('r').
- APPEND_CRLF, 1, when 1 append 0x0D 0x0A (12-byte frame); when 0 the frame is 10 bytes.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  one-cycle request to send a response frame.
- i_raddr  input  8  address to report; sampled when i_start is accepted.
- i_rdata  input  32  data to report; sampled when i_start is accepted.
- i_tx_done  input  1  one-cycle pulse from the UART transmitter when the current byte has finished.
- o_tx_byte  output  8  byte presented to the UART transmitter.
- o_tx_dv  output  1  one-cycle strobe: o_tx_byte is valid, start transmission.
- o_busy  output  1  high from start acceptance until the frame completes.
- o_done  output  1  one-cycle pulse when the last byte has finished.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: o_tx_byte=0, o_tx_dv=0, o_busy=0, o_done=0, state=IDLE, byte index=0, captured regs=0.
  - Reset asserted mid-frame aborts immediately. No further o_tx_dv and no o_done for the aborted frame.
- States:
  - IDLE: o_busy=0. i_start=1 captures i_raddr and i_rdata, clears the byte index, and moves to SEND.
  - SEND: asserts o_tx_dv=1 for exactly one cycle with o_tx_byte = byte[index], then moves to WAIT.
  - WAIT: holds o_tx_byte stable and waits for i_tx_done.
    - On i_tx_done, if index = last: move to IDLE and pulse o_done in that same first IDLE cycle.
    - Otherwise: increment the index and go to SEND.
- Latency:
  - i_start in cycle N gives o_tx_dv in cycle N+1.
  - i_tx_done in cycle M gives the next o_tx_dv in cycle M+1.
  - The final i_tx_done in cycle M gives o_done in cycle M+1.
- Byte map, by index:
  - 0: RESPKEY.
  - 1: captured address, raw (not hex encoded).
  - 2..9: hex(data[3:0]), hex(data[7:4]), ... hex(data[31:28]).
  - 10: 0x0D; 11: 0x0A (present only when APPEND_CRLF=1).
  - Last index is 11 when APPEND_CRLF=1, 9 when APPEND_CRLF=0.
- Hex encoding: nibble 0..9 maps to 0x30..0x39; 10..15 maps to 0x61..0x66 (lowercase only, matching the interpreter decode).
- Boundary cases:
  - i_start while o_busy=1 is ignored. The captured regs do not change and no queueing occurs.
  - i_start in the o_done cycle is accepted, since the state is IDLE; that frame's o_tx_dv follows in the next cycle.
  - i_tx_done outside WAIT, including the o_tx_dv cycle and IDLE, is ignored.
  - Changes to i_raddr and i_rdata after acceptance do not affect the frame in flight.
  - The byte index never exceeds the last index; there is no wrap.
- o_busy = (state != IDLE). o_tx_dv is never high in two consecutive cycles.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0; no o_tx_dv while i_tx_done toggles randomly.
- APPEND_CRLF=1, i_raddr=0x05, i_rdata=0x1234ABCD, i_start; a transmitter model returns i_tx_done 10 cycles after each o_tx_dv -> bytes 0x72,0x05,0x64,0x63,0x62,0x61,0x34,0x33,0x32,0x31,0x0D,0x0A. Exactly 12 o_tx_dv strobes, then o_done one cycle after the 12th i_tx_done.
- APPEND_CRLF=0, i_rdata=0xF0000009, i_raddr=0xFF -> bytes 0x72,0xFF,0x39,0x30,0x30,0x30,0x30,0x30,0x30,0x66. 10 strobes, no CR/LF.
- Second i_start with i_rdata=0xDEADBEEF issued at the 3rd byte of a frame in flight -> ignored; the frame completes with the original data and only one o_done.
- i_start asserted in the o_done cycle -> the new frame's first o_tx_dv (0x72) appears in the next cycle.
- i_rst_n pulled low while waiting for byte 5 -> outputs clear asynchronously. After release: no o_tx_dv, no o_done, and a fresh i_start sends a complete frame.

Source files
------------

// File: rtl/uart_tx_formatter.sv
// Formats a register read response ('r', raw address, 8 hex chars LSN first, optional CR LF)
// and hands it byte-by-byte to a UART transmitter using a dv/done handshake.
module uart_tx_formatter #(
  parameter int unsigned RESPKEY     = 114,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_raddr,
  input  logic [31:0] i_rdata,
  input  logic        i_tx_done,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_dv,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [3:0] LAST_IDX = APPEND_CRLF ? 4'd11 : 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  idx_d;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic [7:0]  tx_byte_q;
  logic        tx_dv_q;
  logic        done_q;

  // Lowercase only: the command interpreter decodes nothing else.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [7:0]  addr,
                                            input logic [31:0] data);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = RESPKEY[7:0];
      4'd1:    b = addr;
      4'd2, 4'd3, 4'd4, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9:
               b = hex_char(data[{idx - 4'd2, 2'b00} +: 4]);
      4'd10:   b = 8'h0D;
      4'd11:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign idx_d = idx_q + 4'd1;

  // The byte and its strobe are loaded on the transition into SEND, so
  // o_tx_dv is high exactly during the single SEND cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      addr_q    <= 8'h00;
      data_q    <= 32'h0;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_q    <= i_raddr;
            data_q    <= i_rdata;
            idx_q     <= 4'd0;
            tx_byte_q <= frame_byte(4'd0, i_raddr, i_rdata);
            tx_dv_q   <= 1'b1;
            state_q   <= SEND;
          end
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (i_tx_done) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q     <= idx_d;
              tx_byte_q <= frame_byte(idx_d, addr_q, data_q);
              tx_dv_q   <= 1'b1;
              state_q   <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_byte = tx_byte_q;
  assign o_tx_dv   = tx_dv_q;
  assign o_done    = done_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_formatter.sv
// Bench for uart_tx_formatter: one CR/LF instance and one without, each driven by
// its own transmitter model and checked every cycle against a frame-level reference.
module tb_uart_tx_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start [2];
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic        tx_done [2];
  logic [7:0]  tx_byte [2];
  logic        tx_dv [2];
  logic        busy [2];
  logic        done [2];

  always #5 clk = ~clk;

  uart_tx_formatter #(.RESPKEY(114), .APPEND_CRLF(1'b1)) u_crlf (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_raddr(raddr), .i_rdata(rdata),
    .i_tx_done(tx_done[0]), .o_tx_byte(tx_byte[0]), .o_tx_dv(tx_dv[0]),
    .o_busy(busy[0]), .o_done(done[0])
  );

  uart_tx_formatter #(.RESPKEY(114), .APPEND_CRLF(1'b0)) u_nocrlf (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_raddr(raddr), .i_rdata(rdata),
    .i_tx_done(tx_done[1]), .o_tx_byte(tx_byte[1]), .o_tx_dv(tx_dv[1]),
    .o_busy(busy[1]), .o_done(done[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: k-th byte of a response, computed straight from the byte map.
  function automatic logic [7:0] ref_byte(input int k, input logic [7:0] a, input logic [31:0] d);
    int nib;
    if (k == 0) return 8'd114;
    if (k == 1) return a;
    if (k >= 2 && k <= 9) begin
      nib = int'((d >> (4 * (k - 2))) & 32'hF);
      return (nib < 10) ? 8'(8'h30 + nib) : 8'(8'h61 + nib - 10);
    end
    if (k == 10) return 8'h0D;
    return 8'h0A;
  endfunction

  // Reference model state, one slot per instance.
  logic [7:0] m_frame [2][12];
  int         m_len [2] = '{12, 10};
  bit         m_busy [2];
  int         m_idx [2];
  bit         m_dv_prev [2];
  logic [7:0] m_hold [2];
  int         dv_cnt [2] = '{0, 0};
  int         done_cnt [2] = '{0, 0};
  logic [7:0] got [2][16];
  int         got_n [2] = '{0, 0};

  // Transmitter model: done pulse dly cycles after each strobe, plus optional noise.
  int dly [2];
  int cnt [2];
  bit noise [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      tx_done[i] = 1'b0;
      if (!rst_n) cnt[i] = 0;
      else if (tx_dv[i]) cnt[i] = dly[i];
      else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) tx_done[i] = 1'b1;
      end
      if (noise[i] && $urandom_range(0, 3) == 0) tx_done[i] = 1'b1;
    end
  end

  // Cycle monitor: inputs are stable here and outputs reflect the edge just taken.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      bit e_dv;
      bit e_done;
      e_dv = 1'b0;
      e_done = 1'b0;
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_dv_prev[i] = 1'b0;
        m_hold[i] = 8'h00;
        check($sformatf("rst_byte%0d", i), tx_byte[i], 8'h00);
      end else begin
        if (!m_busy[i]) begin
          if (start[i]) begin
            for (int k = 0; k < 12; k++) m_frame[i][k] = ref_byte(k, raddr, rdata);
            m_busy[i] = 1'b1;
            m_idx[i] = 0;
            e_dv = 1'b1;
          end
        end else if (tx_done[i] && !m_dv_prev[i]) begin
          if (m_idx[i] == m_len[i] - 1) begin
            m_busy[i] = 1'b0;
            e_done = 1'b1;
          end else begin
            m_idx[i]++;
            e_dv = 1'b1;
          end
        end
        if (e_dv) m_hold[i] = m_frame[i][m_idx[i]];
        if (m_busy[i]) check($sformatf("byte%0d_idx%0d", i, m_idx[i]), tx_byte[i], m_hold[i]);
      end
      check($sformatf("dv%0d", i), tx_dv[i], e_dv);
      check($sformatf("done%0d", i), done[i], e_done);
      check($sformatf("busy%0d", i), busy[i], m_busy[i]);
      if (tx_dv[i]) begin
        dv_cnt[i]++;
        if (got_n[i] < 16) got[i][got_n[i]] = tx_byte[i];
        got_n[i]++;
      end
      if (done[i]) done_cnt[i]++;
      m_dv_prev[i] = e_dv;
    end
  end

  task automatic send(input int i, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    raddr = a;
    rdata = d;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    int n;
    n = 0;
    while (m_busy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy[i], 1'b0);
  endtask

  task automatic wait_dv(input int i, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (dv_cnt[i] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_dv_reached"}, dv_cnt[i] >= target, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_byte%0d", tag, i), tx_byte[i], 8'h00);
      check($sformatf("%s_dv%0d", tag, i), tx_dv[i], 1'b0);
      check($sformatf("%s_busy%0d", tag, i), busy[i], 1'b0);
      check($sformatf("%s_done%0d", tag, i), done[i], 1'b0);
    end
  endtask

  initial begin
    logic [7:0] exp_a [12];
    logic [7:0] exp_b [10];
    int base_dv;
    int base_done;
    int n;

    exp_a = '{8'h72, 8'h05, 8'h64, 8'h63, 8'h62, 8'h61, 8'h34, 8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A};
    exp_b = '{8'h72, 8'hFF, 8'h39, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h66};
    start[0] = 1'b0;
    start[1] = 1'b0;
    raddr = 8'h00;
    rdata = 32'h0;
    dly = '{10, 10};
    noise = '{1'b0, 1'b0};

    // Reset, then 20 idle cycles with a noisy done line.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    noise = '{1'b1, 1'b1};
    repeat (20) @(negedge clk);
    noise = '{1'b0, 1'b0};
    check_zero("idle");

    // Directed CR/LF frame.
    got_n[0] = 0;
    base_done = done_cnt[0];
    send(0, 8'h05, 32'h1234ABCD);
    wait_idle(0, 400, "crlf");
    check("crlf_count", got_n[0], 12);
    for (int k = 0; k < 12; k++) check($sformatf("crlf_b%0d", k), got[0][k], exp_a[k]);
    check("crlf_dones", done_cnt[0] - base_done, 1);

    // Directed frame without CR/LF.
    got_n[1] = 0;
    send(1, 8'hFF, 32'hF0000009);
    wait_idle(1, 400, "nocrlf");
    check("nocrlf_count", got_n[1], 10);
    for (int k = 0; k < 10; k++) check($sformatf("nocrlf_b%0d", k), got[1][k], exp_b[k]);

    // Start at the 3rd byte of a frame in flight is ignored.
    dly[0] = 4;
    got_n[0] = 0;
    base_dv = dv_cnt[0];
    base_done = done_cnt[0];
    send(0, 8'h3C, 32'h0BADF00D);
    wait_dv(0, base_dv + 3, 100, "busy_start");
    raddr = 8'h99;
    rdata = 32'hDEADBEEF;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0, 400, "busy_start");
    check("busy_start_count", got_n[0], 12);
    for (int k = 0; k < 12; k++)
      check($sformatf("busy_start_b%0d", k), got[0][k], ref_byte(k, 8'h3C, 32'h0BADF00D));
    check("busy_start_dones", done_cnt[0] - base_done, 1);

    // Start in the o_done cycle: strobe in the very next cycle.
    dly[1] = 3;
    send(1, 8'h11, 32'h89ABCDEF);
    n = 0;
    while (!done[1] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done[1], 1'b1);
    raddr = 8'h22;
    rdata = 32'h01234567;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("b2b_dv", tx_dv[1], 1'b1);
    check("b2b_byte", tx_byte[1], 8'h72);
    wait_idle(1, 300, "b2b");

    // Reset while waiting for byte 5 aborts the frame.
    dly[0] = 6;
    base_dv = dv_cnt[0];
    send(0, 8'h5A, 32'hCAFE1234);
    wait_dv(0, base_dv + 5, 200, "abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_dv = dv_cnt[0];
    base_done = done_cnt[0];
    repeat (30) @(negedge clk);
    check("abort_no_dv", dv_cnt[0] - base_dv, 0);
    check("abort_no_done", done_cnt[0] - base_done, 0);
    got_n[0] = 0;
    send(0, 8'hA5, 32'h76543210);
    wait_idle(0, 400, "post_abort");
    check("post_abort_count", got_n[0], 12);
    check("post_abort_dones", done_cnt[0] - base_done, 1);

    // Randomized frames with noisy done lines and ignored/back-to-back starts.
    for (int f = 0; f < 24; f++) begin
      int i;
      i = int'($urandom_range(0, 1));
      dly[i] = int'($urandom_range(1, 6));
      noise[i] = 1'($urandom_range(0, 1));
      send(i, 8'($urandom), $urandom);
      n = 0;
      while (m_busy[i] && n < 600) begin
        @(negedge clk);
        n++;
        start[i] = ($urandom_range(0, 7) == 0);
        if (start[i]) begin
          raddr = 8'($urandom);
          rdata = $urandom;
        end
      end
      start[i] = 1'b0;
      noise[i] = 1'b0;
      wait_idle(i, 400, $sformatf("rand%0d", f));
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
